// File: rtl/alu_muldiv_seq.sv
// RV32I ALU with registered results plus the RV32M group on a shared iterative
// shift engine (shift-add multiply, restoring divide), behind a valid/ready handshake.
module alu_muldiv_seq #(
   parameter int unsigned WIDTH_DATA_LENGTH   = 32,
   parameter int unsigned WIDTH_ALUSEL_LENGTH = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH_DATA_LENGTH-1:0]   DataA,
   input  logic [WIDTH_DATA_LENGTH-1:0]   DataB,
   input  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH_DATA_LENGTH-1:0]   DataOut
);
   localparam int unsigned N           = WIDTH_DATA_LENGTH;
   localparam int unsigned SHAMT_WIDTH = $clog2(N);
   localparam int unsigned CntW        = SHAMT_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e          state_q;
   logic [N-1:0]    dout_q;
   logic [N-1:0]    hi_q, lo_q, b_q;
   logic            neg_q;
   logic [2:0]      op_q;
   logic [CntW-1:0] cnt_q;

   logic [SHAMT_WIDTH-1:0] shamt;
   logic [N-1:0]           alu_res;
   logic                   a_signed, b_signed, sa, sb, neg_d;
   logic [N-1:0]           mag_a, mag_b;
   logic [N:0]             mul_sum, div_shift, div_trial;
   logic [N-1:0]           mul_hi_d, mul_lo_d, div_hi_d, div_lo_d;
   logic [2*N-1:0]         prod, prod_c;
   logic [N-1:0]           mul_out, div_val, div_out;
   logic                   div_by_zero, div_ovf;

   assign shamt = DataB[SHAMT_WIDTH-1:0];

   always_comb begin
      alu_res = '0;
      case (ALUSel[3:0])
         4'h0: alu_res = DataA + DataB;
         4'h1: alu_res = DataA - DataB;
         4'h2: alu_res = DataA << shamt;
         4'h3: alu_res = {{(N-1){1'b0}}, $signed(DataA) < $signed(DataB)};
         4'h4: alu_res = {{(N-1){1'b0}}, DataA < DataB};
         4'h5: alu_res = DataA ^ DataB;
         4'h6: alu_res = DataA >> shamt;
         4'h7: alu_res = N'($signed(DataA) >>> shamt);
         4'h8: alu_res = DataA | DataB;
         4'h9: alu_res = DataA & DataB;
         4'hE: alu_res = DataA + DataB + N'(4);
         4'hF: alu_res = DataB;
         default: alu_res = '0;
      endcase
   end

   // Operand signedness for the M group, indexed by ALUSel[2:0]
   always_comb begin
      a_signed = (ALUSel[2:0] == 3'b000) || (ALUSel[2:0] == 3'b001) ||
                 (ALUSel[2:0] == 3'b010) || (ALUSel[2:0] == 3'b100) ||
                 (ALUSel[2:0] == 3'b110);
      b_signed = (ALUSel[2:0] == 3'b000) || (ALUSel[2:0] == 3'b001) ||
                 (ALUSel[2:0] == 3'b100) || (ALUSel[2:0] == 3'b110);
      sa       = a_signed && DataA[N-1];
      sb       = b_signed && DataB[N-1];
      mag_a    = sa ? -DataA : DataA;
      mag_b    = sb ? -DataB : DataB;
      case (ALUSel[2:0])
         3'b000, 3'b001, 3'b100: neg_d = sa ^ sb;
         3'b010, 3'b110:         neg_d = sa;
         default:                neg_d = 1'b0;
      endcase
      div_by_zero = (DataB == '0);
      div_ovf     = !ALUSel[0] && (DataA == {1'b1, {(N-1){1'b0}}}) && (DataB == '1);
   end

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      mul_hi_d  = mul_sum[N:1];
      mul_lo_d  = {mul_sum[0], lo_q[N-1:1]};
      div_shift = {hi_q, lo_q[N-1]};
      div_trial = div_shift - {1'b0, b_q};
      if (!div_trial[N]) begin
         div_hi_d = div_trial[N-1:0];
         div_lo_d = {lo_q[N-2:0], 1'b1};
      end else begin
         div_hi_d = div_shift[N-1:0];
         div_lo_d = {lo_q[N-2:0], 1'b0};
      end
      prod    = {mul_hi_d, mul_lo_d};
      prod_c  = neg_q ? -prod : prod;
      mul_out = (op_q[1:0] == 2'b00) ? prod_c[N-1:0] : prod_c[2*N-1:N];
      div_val = op_q[1] ? div_hi_d : div_lo_d;
      div_out = neg_q ? -div_val : div_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         dout_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  if (!ALUSel[4] || ALUSel[3]) begin
                     dout_q  <= ALUSel[4] ? '0 : alu_res;
                     state_q <= StDone;
                  end else if (ALUSel[2] && div_by_zero) begin
                     dout_q  <= ALUSel[1] ? DataA : '1;
                     state_q <= StDone;
                  end else if (ALUSel[2] && div_ovf) begin
                     dout_q  <= ALUSel[1] ? '0 : DataA;
                     state_q <= StDone;
                  end else begin
                     hi_q    <= '0;
                     lo_q    <= mag_a;
                     b_q     <= mag_b;
                     neg_q   <= neg_d;
                     op_q    <= ALUSel[2:0];
                     cnt_q   <= CntW'(N);
                     state_q <= ALUSel[2] ? StDiv : StMul;
                  end
               end
            end
            StMul: begin
               hi_q  <= mul_hi_d;
               lo_q  <= mul_lo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  dout_q  <= mul_out;
                  state_q <= StDone;
               end
            end
            StDiv: begin
               hi_q  <= div_hi_d;
               lo_q  <= div_lo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  dout_q  <= div_out;
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign DataOut   = dout_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: opcode results, latency, backpressure and async reset.
module tb_alu_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] DataA = '0;
   logic [31:0] DataB = '0;
   logic [4:0]  ALUSel = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] DataOut;

   int checks = 0;
   int failures = 0;

   alu_muldiv_seq #(
      .WIDTH_DATA_LENGTH  (32),
      .WIDTH_ALUSEL_LENGTH(5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .DataA    (DataA),
      .DataB    (DataB),
      .ALUSel   (ALUSel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .DataOut  (DataOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issue one op, wait for out_valid, check edges after accept, in_ready low and result.
   task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
      int edges;
      logic rdy_seen;
      @(negedge clk);
      in_valid = 1'b1;
      ALUSel   = sel;
      DataA    = a;
      DataB    = b;
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      DataA    = 32'hDEAD_BEEF;
      DataB    = 32'h1234_5678;
      ALUSel   = 5'b00001;
      edges    = 0;
      rdy_seen = 1'b0;
      while (!out_valid && edges < 100) begin
         if (in_ready) rdy_seen = 1'b1;
         @(posedge clk);
         #1;
         edges++;
      end
      chk({tag, "_latency"}, edges, exp_edges);
      chk({tag, "_result"}, DataOut, exp);
      if (exp_edges > 0) chk({tag, "_busy_in_ready"}, {31'b0, rdy_seen}, 32'd0);
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_consumed_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_consumed_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      logic hold_bad;
      #12;
      chk("reset_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_dout", DataOut, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("idle_ready", {31'b0, in_ready}, 32'd1);

      run_op("add_wrap", 5'b00000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
      consume("add_wrap");
      run_op("sra", 5'b00111, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);
      consume("sra");
      run_op("slt", 5'b00011, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);
      consume("slt");
      run_op("sltu", 5'b00100, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
      consume("sltu");
      run_op("addp4", 5'b01110, 32'h10, 32'h20, 32'h34, 0);
      consume("addp4");
      run_op("undef0", 5'b01010, 32'h5, 32'h6, 32'h0, 0);
      consume("undef0");
      run_op("undef1", 5'b11000, 32'h5, 32'h6, 32'h0, 0);
      consume("undef1");

      run_op("mulh", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32);
      consume("mulh");
      run_op("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
      consume("mulhu");
      run_op("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      consume("mulhsu");
      run_op("mul", 5'b10000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
      consume("mul");

      run_op("div", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
      consume("div");
      run_op("rem", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
      consume("rem");
      run_op("divu", 5'b10101, 32'd100, 32'd7, 32'd14, 32);
      consume("divu");
      run_op("remu", 5'b10111, 32'd100, 32'd7, 32'd2, 32);
      consume("remu");

      run_op("div_z", 5'b10100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      consume("div_z");
      run_op("remu_z", 5'b10111, 32'd5, 32'd0, 32'd5, 0);
      consume("remu_z");
      run_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      consume("div_ovf");
      run_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
      consume("rem_ovf");

      // Backpressure: result held for 10 cycles while a new request waits
      run_op("bp_div", 5'b10100, 32'd20, 32'd3, 32'd6, 32);
      @(negedge clk);
      in_valid = 1'b1;
      ALUSel   = 5'b00000;
      DataA    = 32'd1;
      DataB    = 32'd1;
      hold_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (!out_valid || DataOut !== 32'd6 || in_ready) hold_bad = 1'b1;
      end
      chk("bp_hold", {31'b0, hold_bad}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
      chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_next_result", DataOut, 32'd2);
      consume("bp_next");

      // Async reset in the middle of a multiply
      @(negedge clk);
      in_valid = 1'b1;
      ALUSel   = 5'b10000;
      DataA    = 32'd9;
      DataB    = 32'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("mid_mul_busy", {31'b0, out_valid}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_async_dout", DataOut, 32'd0);
      chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_async_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst_add", 5'b00000, 32'd2, 32'd3, 32'd5, 0);
      consume("post_rst_add");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Sequential, parametrised successor to the single-cycle RV32I ALU.
- Keeps the full RV32I opcode set, with registered results, and adds the RV32M multiply/divide group. Multiply and divide run on a shared iterative shift engine.
- Sits in the EX stage behind a valid/ready handshake. The pipeline stalls on in_ready/out_valid while a long operation runs.

Parameters:
- WIDTH_DATA_LENGTH, 32, operand/result width; must be a power of two, >= 8.
- WIDTH_ALUSEL_LENGTH, 5, opcode width; bit 4 selects the M group.
- SHAMT_WIDTH, $clog2(WIDTH_DATA_LENGTH), shift-amount bits used from DataB (localparam).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode presented.
- in_ready  output  1  block can accept; high only in IDLE.
- DataA  input  WIDTH_DATA_LENGTH  operand A / rs1.
- DataB  input  WIDTH_DATA_LENGTH  operand B / rs2 / imm.
- ALUSel  input  WIDTH_ALUSEL_LENGTH  operation select.
- out_valid  output  1  DataOut holds a result.
- out_ready  input  1  consumer takes the result.
- DataOut  output  WIDTH_DATA_LENGTH  registered result.

Behaviour:
- Reset: asynchronous, active-high. Forces state=IDLE, DataOut=0, out_valid=0, and all internal accumulator/counter registers to 0. Reset mid-operation aborts the operation with no result produced.
- Opcodes 0xxxx (single-cycle group), on N-bit operands:
  - 00000 ADD; 00001 SUB; 00010 SLL; 00011 SLT (signed); 00100 SLTU; 00101 XOR; 00110 SRL; 00111 SRA; 01000 OR; 01001 AND.
  - 01110 A+B+4; 01111 pass B.
  - All other 0xxxx codes produce 0.
  - Shifts use only DataB[SHAMT_WIDTH-1:0].
  - ADD/SUB wrap modulo 2^N.
- Opcodes 1xxxx (M group):
  - 10000 MUL (low N bits); 10001 MULH (s×s high); 10010 MULHSU (s×u high); 10011 MULHU (u×u high).
  - 10100 DIV; 10101 DIVU; 10110 REM; 10111 REMU.
  - 11xxx produces 0 with single-cycle latency.
- Handshake and states:
  - Acceptance occurs when in_valid && in_ready at a rising edge (call it E0).
  - States: IDLE, MUL, DIV, DONE.
  - IDLE -> DONE at E0 for single-cycle ops; DataOut is loaded at E0, so out_valid is high in the cycle after E0.
  - IDLE -> MUL or DIV at E0 for multiply/divide. Operands are converted to magnitudes, sign flags are latched, and the counter is set to N.
  - MUL/DIV: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. The counter decrements each step.
  - When the counter reaches 0, the FSM goes to DONE on that edge. DataOut is sign-corrected and loaded on the same edge.
  - Multiply/divide latency is exactly N edges: out_valid rises after edge E0+N.
  - DONE: out_valid=1 and DataOut is stable. If out_ready=1 at an edge, the FSM goes to IDLE and out_valid=0. Otherwise it holds indefinitely.
  - in_ready=0 in every state except IDLE. There is no back-to-back overlap; minimum issue interval is 2 cycles.
  - Inputs are sampled only at E0. Changes to DataA/DataB/ALUSel while busy have no effect.
- Divide corner cases. These bypass the engine and go straight to DONE at E0 (latency 1):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = DataA.
  - Signed overflow (DataA = 100…0, DataB = all ones): DIV = DataA; REM = 0.
- Sign rules:
  - Quotient is negative iff operand signs differ (for DIV only).
  - Remainder takes the dividend's sign.
  - MULH/MULHSU negate the 2N-bit product when the result sign is negative.
- in_valid held high in DONE is not accepted until the FSM returns to IDLE.

Test Plan:
- ADD 0x7FFFFFFF + 1, then SRA 0x80000000 by B=0x24 (shamt 4) -> 0x80000000 then 0xF8000000. out_valid rises 1 cycle after each accept.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL 7×(-3) -> 0xFFFFFFEB. out_valid rises exactly 32 edges after accept; in_ready is low throughout.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each at 32-edge latency.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each at 1-cycle latency.
- Backpressure: out_ready=0 for 10 cycles after DIV completes -> DataOut and out_valid hold. A new in_valid is not accepted until 1 edge after out_ready=1.
- Assert rst mid-MUL at edge E0+10 -> outputs 0 immediately (async), state IDLE, in_ready=1 after release. A following ADD 2+3 returns 5.
